// File: rtl/div_issue_hilo_pkg.sv
// Shared encodings and widths for the EX-stage divide controller and HI/LO file.
package div_issue_hilo_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_issue_hilo_hilo_reg.sv
// Architectural HI/LO storage written from WB.
// With HILO_FWD_EN defined, a same-cycle WB write is forwarded to the read ports.
module div_issue_hilo_hilo_reg
  import div_issue_hilo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             whilo,
  input  logic [REG_W-1:0] wb_hi,
  input  logic [REG_W-1:0] wb_lo,
  output logic [REG_W-1:0] hi,
  output logic [REG_W-1:0] lo
);

  logic [REG_W-1:0] hi_q;
  logic [REG_W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else if (whilo) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

`ifdef HILO_FWD_EN
  assign hi = whilo ? wb_hi : hi_q;
  assign lo = whilo ? wb_lo : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule

// File: rtl/div_issue_hilo.sv
// EX-stage divide issue controller: start/annul handshake to the divider, pipeline stall,
// result capture for WB, and the HI/LO register file (HILO_FWD_EN enables WB->read forwarding).
module div_issue_hilo
  import div_issue_hilo_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_div_i,
  input  logic              ex_signed_i,
  input  logic [REG_W-1:0]  ex_rs_i,
  input  logic [REG_W-1:0]  ex_rt_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              stall_req_o,
  output logic              div_start_o,
  output logic              div_annul_o,
  output logic              div_signed_o,
  output logic [REG_W-1:0]  div_op1_o,
  output logic [REG_W-1:0]  div_op2_o,
  input  logic [DREG_W-1:0] div_result_i,
  input  logic              div_ready_i,
  output logic [REG_W-1:0]  div_hi_o,
  output logic [REG_W-1:0]  div_lo_o,
  output logic              div_done_o,
  output logic              div_err_o,
  input  logic              wb_whilo_i,
  input  logic [REG_W-1:0]  wb_hi_i,
  input  logic [REG_W-1:0]  wb_lo_i,
  output logic [REG_W-1:0]  hi_o,
  output logic [REG_W-1:0]  lo_o,
  output div_state_e        dbg_state
);

  // Handshake: div_start_o rises with stable operands and stays high until the
  // result has been consumed (or the divide is annulled); the divider holds
  // div_ready_i/div_result_i for as long as div_start_o stays high.

  localparam int CNT_W = (DIV_TIMEOUT > 0) ? $clog2(DIV_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_TIMEOUT);

  div_state_e       state, state_n;
  logic             start_n, signed_n, done_n, err_n;
  logic [REG_W-1:0] op1_n, op2_n, hi_n, lo_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DIV_IDLE;
      div_start_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= ZERO_WORD;
      div_op2_o    <= ZERO_WORD;
      div_hi_o     <= ZERO_WORD;
      div_lo_o     <= ZERO_WORD;
      div_done_o   <= 1'b0;
      div_err_o    <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_n;
      div_start_o  <= start_n;
      div_signed_o <= signed_n;
      div_op1_o    <= op1_n;
      div_op2_o    <= op2_n;
      div_hi_o     <= hi_n;
      div_lo_o     <= lo_n;
      div_done_o   <= done_n;
      div_err_o    <= err_n;
      cnt          <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    start_n     = div_start_o;
    signed_n    = div_signed_o;
    op1_n       = div_op1_o;
    op2_n       = div_op2_o;
    hi_n        = div_hi_o;
    lo_n        = div_lo_o;
    done_n      = div_done_o;
    err_n       = div_err_o;
    cnt_n       = cnt;
    stall_req_o = 1'b0;
    div_annul_o = 1'b0;
    case (state)
      DIV_IDLE: begin
        stall_req_o = ex_div_i;
        if (ex_div_i && !flush_i) begin
          op1_n    = ex_rs_i;
          op2_n    = ex_rt_i;
          signed_n = ex_signed_i;
          start_n  = 1'b1;
          cnt_n    = '0;
          state_n  = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        stall_req_o = 1'b1;
        // A flush discards even a result arriving in the same cycle.
        if (flush_i) begin
          div_annul_o = 1'b1;
          start_n     = 1'b0;
          cnt_n       = '0;
          state_n     = DIV_IDLE;
        end else if (div_ready_i) begin
          hi_n    = div_result_i[DREG_W-1:REG_W];
          lo_n    = div_result_i[REG_W-1:0];
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = DIV_DONE;
        end else if ((DIV_TIMEOUT != 0) && (cnt != CNT_MAX)) begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CNT_MAX) err_n = 1'b1;
        end
      end
      DIV_DONE: begin
        // Leaving DONE always drops start for one edge before any re-issue.
        if (!stall_i || flush_i) begin
          start_n = 1'b0;
          done_n  = 1'b0;
          state_n = DIV_IDLE;
        end
      end
      default: state_n = DIV_IDLE;
    endcase
  end

  assign dbg_state = state;

  div_issue_hilo_hilo_reg u_hilo (
    .clk   (clk),
    .rst   (rst),
    .whilo (wb_whilo_i),
    .wb_hi (wb_hi_i),
    .wb_lo (wb_lo_i),
    .hi    (hi_o),
    .lo    (lo_o)
  );

endmodule

// File: tb/tb_div_issue_hilo.sv
// Directed bench for div_issue_hilo with a small behavioural divider attached.
module tb_div_issue_hilo;
  import div_issue_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_div_i = 1'b0, ex_signed_i = 1'b0;
  logic [31:0] ex_rs_i = '0, ex_rt_i = '0;
  logic        flush_i = 1'b0, stall_i = 1'b0;
  logic        stall_req_o, div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic [63:0] div_result_i = '0;
  logic        div_ready_i = 1'b0;
  logic [31:0] div_hi_o, div_lo_o;
  logic        div_done_o, div_err_o;
  logic        wb_whilo_i = 1'b0;
  logic [31:0] wb_hi_i = '0, wb_lo_i = '0;
  logic [31:0] hi_o, lo_o;
  div_state_e  dbg_state;

  int tests = 0;
  int fails = 0;
  int lat = 2;
  bit hold_ready = 1'b0;
  int dcnt = 0;

  always #5 clk = ~clk;

  div_issue_hilo #(.DIV_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ex_div_i(ex_div_i), .ex_signed_i(ex_signed_i),
    .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .flush_i(flush_i), .stall_i(stall_i),
    .stall_req_o(stall_req_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i), .div_hi_o(div_hi_o),
    .div_lo_o(div_lo_o), .div_done_o(div_done_o), .div_err_o(div_err_o),
    .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .hi_o(hi_o), .lo_o(lo_o), .dbg_state(dbg_state)
  );

  // Behavioural divider: remainder in [63:32], quotient in [31:0], 0 for divisor 0.
  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a; sb = b;
      sq = sa / sb; sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  always @(posedge clk) begin
    if (rst || !div_start_o) begin
      div_ready_i  <= 1'b0;
      div_result_i <= '0;
      dcnt         <= 0;
    end else if (!div_ready_i && !hold_ready) begin
      if (dcnt >= lat) begin
        div_ready_i  <= 1'b1;
        div_result_i <= div_model(div_signed_o, div_op1_o, div_op2_o);
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the issue edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    ex_div_i = 1'b1; ex_signed_i = s; ex_rs_i = a; ex_rt_i = b;
    #1;
    tests++;
    if (stall_req_o !== 1'b1) begin fails++; $display("FAIL issue_stall: got %b exp 1", stall_req_o); end
    @(negedge clk);
    tests++;
    if (div_start_o !== 1'b1 || div_signed_o !== s || dbg_state !== DIV_BUSY) begin
      fails++; $display("FAIL issue_start: start %b signed %b state %0d exp 1 %b 1", div_start_o, div_signed_o, dbg_state, s);
    end
  endtask

  task automatic wait_done();
    int i = 0;
    while (!div_done_o && i < 30) begin @(negedge clk); i++; end
    tests++;
    if (div_done_o !== 1'b1) begin fails++; $display("FAIL wait_done: timed out, done %b exp 1", div_done_o); end
  endtask

  task automatic finish_div();
    @(negedge clk);
    ex_div_i = 1'b0;
    tests++;
    if (div_done_o !== 1'b0 || div_start_o !== 1'b0) begin
      fails++; $display("FAIL done_pulse: done %b start %b exp 0 0", div_done_o, div_start_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({stall_req_o, div_start_o, div_annul_o, div_signed_o, div_done_o, div_err_o} !== 6'b0 ||
        dbg_state !== DIV_IDLE) begin
      fails++; $display("FAIL reset_ctrl: flags %b state %0d exp 0 0", {stall_req_o, div_start_o, div_annul_o, div_signed_o, div_done_o, div_err_o}, dbg_state);
    end
    tests++;
    if ({div_op1_o, div_op2_o, div_hi_o, div_lo_o, hi_o, lo_o} !== 192'd0) begin
      fails++; $display("FAIL reset_data: op1 %h op2 %h dhi %h dlo %h hi %h lo %h exp 0", div_op1_o, div_op2_o, div_hi_o, div_lo_o, hi_o, lo_o);
    end
  endtask

  task automatic test_divu();
    lat = 2;
    issue(1'b0, 32'd100, 32'd7);
    wait_done();
    tests++;
    if (div_lo_o !== 32'd14 || div_hi_o !== 32'd2 || stall_req_o !== 1'b0) begin
      fails++; $display("FAIL divu_result: lo %0d hi %0d stall %b exp 14 2 0", div_lo_o, div_hi_o, stall_req_o);
    end
    finish_div();
    wb_whilo_i = 1'b1; wb_hi_i = 32'd2; wb_lo_i = 32'd14;
    @(negedge clk);
    wb_whilo_i = 1'b0;
    tests++;
    if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
      fails++; $display("FAIL divu_wb: hi %0d lo %0d exp 2 14", hi_o, lo_o);
    end
  endtask

  task automatic test_signed();
    lat = 3;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    tests++;
    if (div_signed_o !== 1'b1 || dbg_state !== DIV_BUSY) begin
      fails++; $display("FAIL signed_busy: signed %b state %0d exp 1 1", div_signed_o, dbg_state);
    end
    wait_done();
    tests++;
    if (div_lo_o !== 32'hFFFF_FFFD || div_hi_o !== 32'hFFFF_FFFF || div_signed_o !== 1'b1) begin
      fails++; $display("FAIL signed_result: lo %h hi %h signed %b exp fffffffd ffffffff 1", div_lo_o, div_hi_o, div_signed_o);
    end
    finish_div();
  endtask

  task automatic test_div_zero();
    lat = 2;
    issue(1'b1, 32'd5, 32'd0);
    wait_done();
    tests++;
    if (div_lo_o !== 32'd0 || div_hi_o !== 32'd0 || div_err_o !== 1'b0) begin
      fails++; $display("FAIL div_zero: lo %h hi %h err %b exp 0 0 0", div_lo_o, div_hi_o, div_err_o);
    end
    finish_div();
  endtask

  task automatic test_flush();
    lat = 10;
    issue(1'b0, 32'd50, 32'd5);
    repeat (3) @(negedge clk);
    flush_i = 1'b1;
    #1;
    tests++;
    if (div_annul_o !== 1'b1 || div_start_o !== 1'b1) begin
      fails++; $display("FAIL flush_annul: annul %b start %b exp 1 1", div_annul_o, div_start_o);
    end
    @(negedge clk);
    flush_i = 1'b0; ex_div_i = 1'b0;
    tests++;
    if (div_annul_o !== 1'b0 || div_start_o !== 1'b0 || div_done_o !== 1'b0 || dbg_state !== DIV_IDLE) begin
      fails++; $display("FAIL flush_idle: annul %b start %b done %b state %0d exp 0 0 0 0", div_annul_o, div_start_o, div_done_o, dbg_state);
    end
    lat = 2;
    issue(1'b0, 32'd9, 32'd3);
    wait_done();
    tests++;
    if (div_lo_o !== 32'd3 || div_hi_o !== 32'd0) begin
      fails++; $display("FAIL flush_next: lo %0d hi %0d exp 3 0", div_lo_o, div_hi_o);
    end
    finish_div();
  endtask

  task automatic test_back_to_back();
    lat = 2;
    stall_i = 1'b1;
    issue(1'b0, 32'd20, 32'd6);
    wait_done();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (div_done_o !== 1'b1 || div_start_o !== 1'b1 || div_lo_o !== 32'd3 || div_hi_o !== 32'd2 ||
          dbg_state !== DIV_DONE) begin
        fails++; $display("FAIL stall_hold: k %0d done %b start %b lo %0d hi %0d state %0d exp 1 1 3 2 2", k, div_done_o, div_start_o, div_lo_o, div_hi_o, dbg_state);
      end
    end
    stall_i = 1'b0;
    @(negedge clk);
    tests++;
    if (div_start_o !== 1'b0 || div_done_o !== 1'b0 || dbg_state !== DIV_IDLE) begin
      fails++; $display("FAIL b2b_gap: start %b done %b state %0d exp 0 0 0", div_start_o, div_done_o, dbg_state);
    end
    ex_rs_i = 32'd8; ex_rt_i = 32'd2;
    @(negedge clk);
    tests++;
    if (div_start_o !== 1'b1 || div_op1_o !== 32'd8 || div_op2_o !== 32'd2) begin
      fails++; $display("FAIL b2b_start: start %b op1 %0d op2 %0d exp 1 8 2", div_start_o, div_op1_o, div_op2_o);
    end
    wait_done();
    tests++;
    if (div_lo_o !== 32'd4 || div_hi_o !== 32'd0) begin
      fails++; $display("FAIL b2b_result: lo %0d hi %0d exp 4 0", div_lo_o, div_hi_o);
    end
    finish_div();
  endtask

  task automatic test_hilo_fwd();
    logic [31:0] exp_hi, exp_lo;
`ifdef HILO_FWD_EN
    exp_hi = 32'hAAAA_5555; exp_lo = 32'h0F0F_0F0F;
`else
    exp_hi = 32'd2; exp_lo = 32'd14;
`endif
    wb_whilo_i = 1'b1; wb_hi_i = 32'hAAAA_5555; wb_lo_i = 32'h0F0F_0F0F;
    #1;
    tests++;
    if (hi_o !== exp_hi || lo_o !== exp_lo) begin
      fails++; $display("FAIL hilo_same_cycle: hi %h lo %h exp %h %h", hi_o, lo_o, exp_hi, exp_lo);
    end
    @(negedge clk);
    wb_whilo_i = 1'b0; wb_hi_i = '0; wb_lo_i = '0;
    #1;
    tests++;
    if (hi_o !== 32'hAAAA_5555 || lo_o !== 32'h0F0F_0F0F) begin
      fails++; $display("FAIL hilo_reg: hi %h lo %h exp aaaa5555 0f0f0f0f", hi_o, lo_o);
    end
  endtask

  task automatic test_timeout();
    hold_ready = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'd1, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests++;
      if (div_err_o !== (k == 8) || dbg_state !== DIV_BUSY) begin
        fails++; $display("FAIL timeout_cnt: k %0d err %b state %0d exp %0d 1", k, div_err_o, dbg_state, (k == 8));
      end
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; ex_div_i = 1'b0; hold_ready = 1'b0;
    tests++;
    if (div_err_o !== 1'b1 || dbg_state !== DIV_IDLE) begin
      fails++; $display("FAIL timeout_sticky: err %b state %0d exp 1 0", div_err_o, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_hilo_fwd();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
